// File: rtl/rst_domain_sequencer.sv
// rtl/rst_domain_sequencer.sv - ordered per-domain reset release with soft reset and capture registers
// Domains leave reset one by one after a global reset; each may then be soft-reset on its own request.
module rst_domain_sequencer #(
    parameter int                    NUM_DOMAINS = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    HOLD_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_DOMAINS-1:0]            sw_rst_req,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              data_valid,
    output logic [NUM_DOMAINS-1:0]            domain_rst_out,
    output logic [NUM_DOMAINS*DATA_WIDTH-1:0] data_out,
    output logic                              seq_done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(NUM_DOMAINS + 1);
    localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ASSERT_ALL,
        RELEASE,
        RUN
    } state_t;

    state_t                            state_q, state_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic                              seq_done_q, seq_done_d;
    logic [NUM_DOMAINS-1:0]            rst_out_q, rst_out_d;
    logic [CW-1:0]                     scnt_q [NUM_DOMAINS];
    logic [CW-1:0]                     scnt_d [NUM_DOMAINS];
    logic [NUM_DOMAINS*DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_DOMAINS-1:0]            released;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        seq_done_d = seq_done_q;
        rst_out_d  = rst_out_q;
        scnt_d     = scnt_q;
        data_d     = data_q;
        released   = '0;

        case (state_q)
            ASSERT_ALL: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                if (cnt_q == HOLD_M1) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IW'(i)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d    = RUN;
                        seq_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = ASSERT_ALL;
            end
        endcase

        // Soft resets only touch domains the sequencer has already let go of.
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            released[i] = (state_q == RUN) || (idx_q > IW'(i));
            if (released[i]) begin
                if (sw_rst_req[i]) begin
                    rst_out_d[i] = 1'b1;
                    scnt_d[i]    = HOLD_LD;
                end else if (scnt_q[i] != '0) begin
                    scnt_d[i] = scnt_q[i] - 1'b1;
                    if (scnt_q[i] == CW'(1)) begin
                        rst_out_d[i] = 1'b0;
                    end
                end
            end
        end

        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (rst_out_q[i]) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = RESET_VALUE;
            end else if (data_valid) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ASSERT_ALL;
            idx_q      <= '0;
            cnt_q      <= '0;
            seq_done_q <= 1'b0;
            rst_out_q  <= '1;
            data_q     <= {NUM_DOMAINS{RESET_VALUE}};
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                scnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            seq_done_q <= seq_done_d;
            rst_out_q  <= rst_out_d;
            data_q     <= data_d;
            scnt_q     <= scnt_d;
        end
    end

    assign domain_rst_out = rst_out_q;
    assign data_out       = data_q;
    assign seq_done       = seq_done_q;

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// tb/tb_rst_domain_sequencer.sv - randomized check of rst_domain_sequencer against an edge-count model
module tb_rst_domain_sequencer;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam logic [W-1:0] RV = 8'h00;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     sw_rst_req;
    logic [W-1:0]     data_in;
    logic             data_valid;
    logic [N-1:0]     domain_rst_out;
    logic [N*W-1:0]   data_out;
    logic             seq_done;

    int checks   = 0;
    int failures = 0;

    // Model: edges since rst dropped, last honoured request edge per domain.
    int           edge_n;
    int           last_req [N];
    bit           exp_rst  [N];
    logic [W-1:0] exp_slice[N];
    bit           exp_done;

    rst_domain_sequencer #(
        .NUM_DOMAINS(N),
        .DATA_WIDTH (W),
        .HOLD_CYCLES(H),
        .RESET_VALUE(RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_rst_req    (sw_rst_req),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .domain_rst_out(domain_rst_out),
        .data_out      (data_out),
        .seq_done      (seq_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d obs=%0h exp=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit prev_rst [N];
        if (rst) begin
            edge_n   = 0;
            exp_done = 1'b0;
            for (int i = 0; i < N; i++) begin
                last_req[i]  = -1;
                exp_rst[i]   = 1'b1;
                exp_slice[i] = RV;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < N; i++) prev_rst[i] = exp_rst[i];
            for (int i = 0; i < N; i++) begin
                int rel_edge;
                rel_edge = (i + 1) * H + 1;
                if (edge_n > rel_edge && sw_rst_req[i]) last_req[i] = edge_n;
                exp_rst[i] = (edge_n < rel_edge) ||
                             (last_req[i] >= 0 && edge_n < last_req[i] + H);
                if (prev_rst[i])     exp_slice[i] = RV;
                else if (data_valid) exp_slice[i] = data_in;
            end
            exp_done = (edge_n >= N * H + 1);
        end
    endtask

    task automatic step();
        logic [N-1:0]   e_rst;
        logic [N*W-1:0] e_data;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            e_rst[i]             = exp_rst[i];
            e_data[i*W +: W]     = exp_slice[i];
        end
        check("domain_rst_out", 64'(domain_rst_out), 64'(e_rst));
        check("seq_done",       64'(seq_done),       64'(exp_done));
        check("data_out",       64'(data_out),       64'(e_data));
    endtask

    initial begin
        rst        = 1'b1;
        sw_rst_req = '0;
        data_in    = '0;
        data_valid = 1'b0;
        edge_n     = 0;
        for (int i = 0; i < N; i++) begin
            last_req[i]  = -1;
            exp_rst[i]   = 1'b1;
            exp_slice[i] = RV;
        end
        exp_done = 1'b0;
        @(negedge clk);

        for (int ep = 0; ep < 30; ep++) begin
            int  rlen, len, hs;
            bit  hold_mode, mid_rst;
            rlen      = 1 + int'($urandom_range(0, 2));
            len       = 30 + int'($urandom_range(0, 40));
            hs        = int'($urandom_range(18, 40));
            hold_mode = ($urandom_range(0, 2) == 0);
            mid_rst   = ($urandom_range(0, 4) == 0);
            rst = 1'b1;
            for (int c = 0; c < rlen; c++) begin
                sw_rst_req = N'($urandom);
                data_valid = 1'($urandom);
                data_in    = W'($urandom);
                step();
            end
            rst = 1'b0;
            for (int c = 0; c < len; c++) begin
                rst        = mid_rst && (c == 9);
                data_valid = ($urandom_range(0, 3) != 0);
                data_in    = W'($urandom);
                for (int i = 0; i < N; i++) begin
                    sw_rst_req[i] = ($urandom_range(0, 9) == 0);
                end
                // Early request well before domain 3 has been released.
                if (c == 5) sw_rst_req[3] = 1'b1;
                if (hold_mode && c >= hs && c < hs + 10) sw_rst_req[0] = 1'b1;
                if (hold_mode && c == hs + 3) sw_rst_req[1] = 1'b1;
                step();
            end
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_domain_sequencer.md
Name: rst_domain_sequencer

Overview:
Parametrised reset-domain controller generalising independent per-domain reset handling to NUM_DOMAINS channels on a single clock. After global reset it holds every domain in reset, then releases them in ascending index order with a programmable hold time per step. Once a domain is released, it can be soft-reset individually by its own request. Each domain owns a DATA_WIDTH capture register that is cleared while the domain is in reset and otherwise loads shared input data. The block sits between the SoC reset source and per-domain datapath logic.

Parameters:
NUM_DOMAINS, 4, number of independent reset domains (>=1)
DATA_WIDTH, 8, width of shared data_in and of each per-domain output register
HOLD_CYCLES, 4, clock edges each domain is held per sequencing step or soft reset (>=1)
RESET_VALUE, 0, value of each data_out slice while its domain is in reset

Ports:
clk  input  1  single clock for all logic
rst  input  1  global reset; synchronous, active-high
sw_rst_req  input  NUM_DOMAINS  per-domain soft-reset request, level-sensitive
data_in  input  DATA_WIDTH  shared data for all domains
data_valid  input  1  qualifies data_in
domain_rst_out  output  NUM_DOMAINS  per-domain reset, active-high, registered
data_out  output  NUM_DOMAINS*DATA_WIDTH  slice i = domain i register, bits [i*DATA_WIDTH +: DATA_WIDTH]
seq_done  output  1  high once power-on sequencing has completed

Behaviour:
- Reset: one clock, synchronous active-high rst.
  - While rst is sampled high: state=ASSERT_ALL, domain_rst_out all 1s, every data_out slice=RESET_VALUE, seq_done=0, idx=0, cnt=0, all soft counters=0.
- Sequencer FSM with states ASSERT_ALL, RELEASE and RUN:
  - ASSERT_ALL -> RELEASE on the first edge with rst low; cnt=0.
  - RELEASE: each edge, cnt increments. At the edge where cnt==HOLD_CYCLES-1 is observed: clear domain_rst_out[idx], cnt=0, idx=idx+1.
  - When the released domain is NUM_DOMAINS-1: go to RUN and set seq_done=1 on that same edge.
  - RUN is terminal until rst.
- Release timing: number edges from 1, where edge 1 is the first edge with rst low. Domain i is released at edge (i+1)*HOLD_CYCLES+1.
- Soft reset, per domain i:
  - Honoured only when domain i has already been released by the sequencer (idx>i or state==RUN). Before that it is ignored.
  - On an edge with sw_rst_req[i]=1: domain_rst_out[i]=1 and scnt[i]=HOLD_CYCLES. Holding the request keeps reloading scnt[i].
  - On an edge with the request low and scnt[i]!=0: scnt[i] decrements. At the edge where scnt[i]==1 is observed, domain_rst_out[i] clears.
  - Net effect: a request last sampled high at edge k releases the domain at edge k+HOLD_CYCLES.
- Soft resets of different domains are fully independent and may overlap. A soft reset does not affect seq_done, idx or other domains.
- Data path, per domain:
  - If domain_rst_out[i] (registered value) is 1: data_out slice i <= RESET_VALUE.
  - Else if data_valid: slice i <= data_in.
  - Else: slice i holds.
  - The first capture after a release happens one edge after domain_rst_out[i] falls.
- rst asserted mid-sequence or mid-soft-reset:
  - Immediately returns to the full reset state on that edge.
  - Sequencing restarts from domain 0 after rst drops.
- Widths:
  - cnt and scnt are $clog2(HOLD_CYCLES+1) bits.
  - idx is $clog2(NUM_DOMAINS+1) bits.
  - No wrap-around is possible.

Test Plan:
- Power-on (N=4, HOLD=4): drop rst -> domain_rst_out goes 1111 to 1110 at edge 5, 1100 at edge 9, 1000 at edge 13, 0000 at edge 17; seq_done rises at edge 17.
- Data capture: after edge 17, drive data_valid=1 with data_in=8'hA5 -> all four slices = 8'hA5 next edge; with data_valid=0 and data_in=8'h3C -> slices hold 8'hA5.
- Soft reset: in RUN, pulse sw_rst_req[2] for one edge k -> domain_rst_out=0100 from k to k+3, 0000 at k+4; slice 2 = 8'h00 during the hold; other slices keep 8'hA5; seq_done stays 1.
- Early soft request: assert sw_rst_req[3] at edge 6 (domain 3 still held) -> ignored; domain 3 still releases exactly at edge 17.
- Held/overlapping requests: hold sw_rst_req[0] high for 10 edges while pulsing sw_rst_req[1] once -> domain 1 releases 4 edges after its pulse; domain 0 releases 4 edges after its request drops.
- Mid-sequence reset: assert rst at edge 10 -> all domains 1, slices=RESET_VALUE, seq_done=0; after rst drops, release times restart from edge 1 (5, 9, 13, 17).
